// File: rtl/pio_fifo_pkg.sv
// Shared constants and types for the PIO TX/RX FIFO pair.
package pio_pkg;

    // Default data word width.
    localparam int WIDTH = 32;

    // Default entries per FIFO when the pair is not joined.
    localparam int DEPTH = 4;

    // A level must be able to count 0..2*DEPTH inclusive.
    localparam int LEVEL_W = $clog2(2 * DEPTH) + 1;

    typedef logic [LEVEL_W-1:0] level_t;

    // How the shared storage is split between the two FIFOs.
    typedef enum logic [1:0] {
        SPLIT   = 2'd0,
        JOIN_TX = 2'd1,
        JOIN_RX = 2'd2
    } join_mode_e;

    // join_tx dominates; join_rx only counts when join_tx is low.
    function automatic join_mode_e join_decode(input logic join_tx, input logic join_rx);
        if (join_tx) begin
            return JOIN_TX;
        end
        if (join_rx) begin
            return JOIN_RX;
        end
        return SPLIT;
    endfunction

endpackage

// File: rtl/pio_fifo_ptr.sv
// Pointer, level and flag bookkeeping for one FIFO living in a slice of the
// shared storage array. The slice is described by a base offset and a
// capacity; both come from the join decode in the parent and may change only
// on an edge that also clears this FIFO.
module pio_fifo_ptr #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(2 * DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [LW-1:0] cap_i,
    input  logic [AW-1:0] base_i,
    input  logic          wr_req_i,
    input  logic          rd_req_i,
    output logic          wr_accept_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [LW-1:0] level_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [AW-1:0] rptr_q;
    logic [AW-1:0] rptr_d;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          empty_q;
    logic          full_q;
    logic          rd_take;

    // Advance a pointer, wrapping at the current capacity rather than at a
    // power of two so the same logic serves DEPTH and 2*DEPTH slices.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p, input logic [LW-1:0] cap);
        if ({1'b0, p} == cap - 1'b1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // A pop needs a non-empty FIFO; a write needs room or a same-cycle pop.
    // A clear suppresses both so nothing moves on a flush edge.
    assign rd_take     = en_i && rd_req_i && !empty_q && !clear_i;
    assign wr_accept_o = en_i && wr_req_i && (!full_q || rd_take) && !clear_i;

    // Next-state pointers and level.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (clear_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (rd_take) begin
                rptr_d = wrap_inc(rptr_q, cap_i);
            end
            if (wr_accept_o) begin
                wptr_d = wrap_inc(wptr_q, cap_i);
            end
            case ({wr_accept_o, rd_take})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer/level state, with flags registered from the next-state level
    // so they are exact right after each edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == cap_i);
        end
    end

    assign wr_addr_o = base_i + wptr_q;
    assign rd_addr_o = base_i + rptr_q;
    assign level_o   = level_q;

    // A disabled FIFO looks both empty and full to everyone.
    assign empty_o = empty_q || !en_i;
    assign full_o  = full_q || !en_i;

endmodule

// File: rtl/pio_fifo.sv
// TX/RX FIFO pair between the host bus and one PIO state machine.
// TX: host writes, machine pulls. RX: machine pushes, host reads.
// Both FIFOs share one 2*DEPTH array; a join lends all of it to one side.
module pio_fifo
    import pio_pkg::*;
#(
    parameter int WIDTH = pio_pkg::WIDTH,
    parameter int DEPTH = pio_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      join_tx,
    input  logic                      join_rx,
    input  logic                      tx_wr,
    input  logic [WIDTH-1:0]          tx_wdata,
    output logic                      tx_full,
    output logic [$clog2(2*DEPTH):0]  tx_level,
    input  logic                      rx_rd,
    output logic [WIDTH-1:0]          rx_rdata,
    output logic                      rx_empty,
    output logic [$clog2(2*DEPTH):0]  rx_level,
    input  logic                      pull,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    output logic                      full,
    output logic                      tx_over,
    output logic                      rx_under,
    input  logic                      err_clr
);

    localparam int AW = $clog2(2 * DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [2*DEPTH];

    join_mode_e    mode_cur;
    join_mode_e    mode_q;
    join_mode_e    mode_eff;
    logic          mode_vld_q;
    logic          mode_chg;
    logic          flush_eff;

    logic          tx_en;
    logic          rx_en;
    logic [LW-1:0] tx_cap;
    logic [LW-1:0] rx_cap;
    logic [AW-1:0] rx_base;

    logic          tx_acc;
    logic [AW-1:0] tx_waddr;
    logic [AW-1:0] tx_raddr;
    logic          rx_acc;
    logic [AW-1:0] rx_waddr;
    logic [AW-1:0] rx_raddr;

    logic          tx_over_q;
    logic          tx_over_d;
    logic          rx_under_q;
    logic          rx_under_d;

    // Join decode. Until the first edge after reset the registered mode is
    // not yet loaded, so the live inputs stand in for it; after that any
    // difference between live and registered mode is a mode change.
    assign mode_cur  = join_decode(join_tx, join_rx);
    assign mode_eff  = mode_vld_q ? mode_q : mode_cur;
    assign mode_chg  = mode_vld_q && (mode_cur != mode_q);
    assign flush_eff = flush || mode_chg;

    assign tx_en   = (mode_eff != JOIN_RX);
    assign rx_en   = (mode_eff != JOIN_TX);
    assign tx_cap  = (mode_eff == JOIN_TX) ? LW'(2 * DEPTH) : LW'(DEPTH);
    assign rx_cap  = (mode_eff == JOIN_RX) ? LW'(2 * DEPTH) : LW'(DEPTH);
    assign rx_base = (mode_eff == JOIN_RX) ? '0 : AW'(DEPTH);

    // Registered join mode, used to detect mode changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= SPLIT;
            mode_vld_q <= 1'b0;
        end else begin
            mode_q     <= mode_cur;
            mode_vld_q <= 1'b1;
        end
    end

    pio_fifo_ptr #(.DEPTH(DEPTH)) u_tx_ptr (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .clear_i     (flush_eff),
        .en_i        (tx_en),
        .cap_i       (tx_cap),
        .base_i      ('0),
        .wr_req_i    (tx_wr),
        .rd_req_i    (pull),
        .wr_accept_o (tx_acc),
        .wr_addr_o   (tx_waddr),
        .rd_addr_o   (tx_raddr),
        .level_o     (tx_level),
        .empty_o     (empty),
        .full_o      (tx_full)
    );

    pio_fifo_ptr #(.DEPTH(DEPTH)) u_rx_ptr (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .clear_i     (flush_eff),
        .en_i        (rx_en),
        .cap_i       (rx_cap),
        .base_i      (rx_base),
        .wr_req_i    (push),
        .rd_req_i    (rx_rd),
        .wr_accept_o (rx_acc),
        .wr_addr_o   (rx_waddr),
        .rd_addr_o   (rx_raddr),
        .level_o     (rx_level),
        .empty_o     (rx_empty),
        .full_o      (full)
    );

    // Shared storage. The two write ports never alias: in split mode they
    // own different halves, in a joined mode only one side is enabled.
    always_ff @(posedge clk) begin
        if (tx_acc) begin
            mem_q[tx_waddr] <= tx_wdata;
        end
        if (rx_acc) begin
            mem_q[rx_waddr] <= din;
        end
    end

    // Show-ahead heads; an empty FIFO reads as zero.
    assign dout     = empty    ? '0 : mem_q[tx_raddr];
    assign rx_rdata = rx_empty ? '0 : mem_q[rx_raddr];

    // Sticky error flags: a set beats err_clr, and a flush freezes both.
    always_comb begin
        tx_over_d  = tx_over_q;
        rx_under_d = rx_under_q;
        if (!flush_eff) begin
            if (tx_wr && !tx_acc) begin
                tx_over_d = 1'b1;
            end else if (err_clr) begin
                tx_over_d = 1'b0;
            end
            if (rx_rd && rx_empty) begin
                rx_under_d = 1'b1;
            end else if (err_clr) begin
                rx_under_d = 1'b0;
            end
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_over_q  <= 1'b0;
            rx_under_q <= 1'b0;
        end else begin
            tx_over_q  <= tx_over_d;
            rx_under_q <= rx_under_d;
        end
    end

    assign tx_over  = tx_over_q;
    assign rx_under = rx_under_q;

endmodule

// File: tb/tb_pio_fifo.sv
// Bench for pio_fifo: a queue-based model of both FIFOs checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pio_fifo;
  import pio_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(2 * D) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          join_tx = 1'b0;
  logic          join_rx = 1'b0;
  logic          tx_wr = 1'b0;
  logic [W-1:0]  tx_wdata = '0;
  logic          rx_rd = 1'b0;
  logic          pull = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  din = '0;
  logic          err_clr = 1'b0;

  logic          tx_full;
  logic [LW-1:0] tx_level;
  logic [W-1:0]  rx_rdata;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  logic [W-1:0]  dout;
  logic          empty;
  logic          full;
  logic          tx_over;
  logic          rx_under;

  pio_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .join_tx  (join_tx),
    .join_rx  (join_rx),
    .tx_wr    (tx_wr),
    .tx_wdata (tx_wdata),
    .tx_full  (tx_full),
    .tx_level (tx_level),
    .rx_rd    (rx_rd),
    .rx_rdata (rx_rdata),
    .rx_empty (rx_empty),
    .rx_level (rx_level),
    .pull     (pull),
    .dout     (dout),
    .empty    (empty),
    .push     (push),
    .din      (din),
    .full     (full),
    .tx_over  (tx_over),
    .rx_under (rx_under),
    .err_clr  (err_clr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each FIFO is a queue; a disabled FIFO has capacity 0, which makes it
  // read as empty and full at once. Mode: 0 split, 1 join TX, 2 join RX.
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  bit m_over = 1'b0;
  bit m_under = 1'b0;
  int m_mode = 0;

  function automatic int live_mode();
    return join_tx ? 1 : (join_rx ? 2 : 0);
  endfunction

  function automatic int tx_cap_of(input int m);
    return (m == 1) ? 2 * D : ((m == 2) ? 0 : D);
  endfunction

  function automatic int rx_cap_of(input int m);
    return (m == 2) ? 2 * D : ((m == 1) ? 0 : D);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int  m;
    int  tcap;
    int  rcap;
    bit  fl;
    bit  tpop;
    bit  tacc;
    bit  rpop;
    bit  racc;
    if (!reset_n) begin
      txq.delete();
      rxq.delete();
      m_over  = 1'b0;
      m_under = 1'b0;
      m_mode  = live_mode();
    end else begin
      m  = live_mode();
      fl = flush || (m != m_mode);
      m_mode = m;
      if (fl) begin
        txq.delete();
        rxq.delete();
      end else begin
        tcap = tx_cap_of(m_mode);
        rcap = rx_cap_of(m_mode);
        tpop = pull && (txq.size() > 0);
        tacc = tx_wr && (tcap > 0) && ((txq.size() < tcap) || tpop);
        rpop = rx_rd && (rxq.size() > 0);
        racc = push && (rcap > 0) && ((rxq.size() < rcap) || rpop);
        if (tpop) void'(txq.pop_front());
        if (tacc) txq.push_back(tx_wdata);
        if (rpop) void'(rxq.pop_front());
        if (racc) rxq.push_back(din);
        if (tx_wr && !tacc) m_over = 1'b1;
        else if (err_clr) m_over = 1'b0;
        if (rx_rd && !rpop) m_under = 1'b1;
        else if (err_clr) m_under = 1'b0;
      end
    end
  end

  // One compare process, on the edge away from the active one.
  always @(negedge clk) begin
    chk("m_tx_level", W'(tx_level), W'(txq.size()));
    chk("m_rx_level", W'(rx_level), W'(rxq.size()));
    chk("m_empty",    W'(empty),    W'(txq.size() == 0));
    chk("m_tx_full",  W'(tx_full),  W'(txq.size() == tx_cap_of(m_mode)));
    chk("m_rx_empty", W'(rx_empty), W'(rxq.size() == 0));
    chk("m_full",     W'(full),     W'(rxq.size() == rx_cap_of(m_mode)));
    chk("m_dout",     dout,         (txq.size() > 0) ? txq[0] : '0);
    chk("m_rx_rdata", rx_rdata,     (rxq.size() > 0) ? rxq[0] : '0);
    chk("m_tx_over",  W'(tx_over),  W'(m_over));
    chk("m_rx_under", W'(rx_under), W'(m_under));
  end

  // ---------------- driver tasks ----------------
  // Inputs are set just after a rising edge and held for one full cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    tx_wr = 1'b0; pull = 1'b0; push = 1'b0; rx_rd = 1'b0;
    flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d);
    tx_wr = 1'b1; tx_wdata = d; tick();
  endtask

  task automatic psh(input logic [W-1:0] d);
    push = 1'b1; din = d; tick();
  endtask

  // Machine samples dout in the cycle it pulls.
  task automatic pul(input logic [W-1:0] exp);
    chk("pull_data", dout, exp); pull = 1'b1; tick();
  endtask

  task automatic rd(input logic [W-1:0] exp);
    chk("rd_data", rx_rdata, exp); rx_rd = 1'b1; tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_level"}, W'(tx_level), '0);
    chk({tag, "_rx_level"}, W'(rx_level), '0);
    chk({tag, "_empty"},    W'(empty), W'(1));
    chk({tag, "_rx_empty"}, W'(rx_empty), W'(1));
    chk({tag, "_tx_full"},  W'(tx_full), '0);
    chk({tag, "_full"},     W'(full), '0);
    chk({tag, "_dout"},     dout, '0);
    chk({tag, "_rx_rdata"}, rx_rdata, '0);
    chk({tag, "_tx_over"},  W'(tx_over), '0);
    chk({tag, "_rx_under"}, W'(rx_under), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1; reset_n = 1'b1;
    tick();

    // TX overflow
    for (int i = 1; i <= 4; i++) wr(W'(i) * 32'h11111111);
    chk("ovf_full", W'(tx_full), W'(1));
    chk("ovf_level", W'(tx_level), W'(4));
    wr(32'h55555555);
    chk("ovf_flag", W'(tx_over), W'(1));
    chk("ovf_level_kept", W'(tx_level), W'(4));
    for (int i = 1; i <= 4; i++) pul(W'(i) * 32'h11111111);
    chk("ovf_drained", W'(empty), W'(1));
    chk("ovf_dout0", dout, '0);
    pull = 1'b1; tick();                     // pull on empty: ignored, no flag
    chk("pull_empty_level", W'(tx_level), '0);
    err_clr = 1'b1; tick();
    chk("ovf_clr", W'(tx_over), '0);

    // RX underflow
    psh(32'hDEADBEEF);
    chk("und_head", rx_rdata, 32'hDEADBEEF);
    chk("und_level", W'(rx_level), W'(1));
    rd(32'hDEADBEEF);
    chk("und_empty", W'(rx_empty), W'(1));
    rx_rd = 1'b1; tick();
    chk("und_flag", W'(rx_under), W'(1));
    chk("und_level0", W'(rx_level), '0);
    rx_rd = 1'b1; err_clr = 1'b1; tick();    // set wins over clear
    chk("und_set_wins", W'(rx_under), W'(1));
    err_clr = 1'b1; tick();
    chk("und_clr", W'(rx_under), '0);

    // Simultaneous write + pull on full TX
    for (int i = 1; i <= 4; i++) wr(W'(i) * 32'h11111111);
    tx_wr = 1'b1; tx_wdata = 32'h66666666;
    chk("sim_full_head", dout, 32'h11111111);
    pull = 1'b1; tick();
    chk("sim_full_level", W'(tx_level), W'(4));
    chk("sim_full_flag", W'(tx_full), W'(1));
    chk("sim_no_over", W'(tx_over), '0);
    pul(32'h22222222); pul(32'h33333333); pul(32'h44444444); pul(32'h66666666);
    chk("sim_full_empty", W'(empty), W'(1));

    // Simultaneous write + pull on empty TX
    tx_wr = 1'b1; tx_wdata = 32'h77777777; pull = 1'b1; tick();
    chk("sim_empty_level", W'(tx_level), W'(1));
    chk("sim_empty_dout", dout, 32'h77777777);
    pul(32'h77777777);

    // Flush vs traffic
    rx_rd = 1'b1; tick();                    // rx_under = 1
    wr(32'hA1A1A1A1);
    psh(32'hB2B2B2B2);
    flush = 1'b1; tx_wr = 1'b1; tx_wdata = 32'hC3C3C3C3;
    push = 1'b1; din = 32'hD4D4D4D4; tick();
    chk("fl_tx_level", W'(tx_level), '0);
    chk("fl_rx_level", W'(rx_level), '0);
    chk("fl_dout", dout, '0);
    chk("fl_rx_rdata", rx_rdata, '0);
    chk("fl_under_kept", W'(rx_under), W'(1));
    err_clr = 1'b1; tick();

    // TX join: 2*D entries, RX held empty+full
    join_tx = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      chk("jtx_not_full", W'(tx_full), '0);
      wr(32'h10000000 + W'(i));
    end
    chk("jtx_level", W'(tx_level), W'(8));
    chk("jtx_full", W'(tx_full), W'(1));
    chk("jtx_rx_empty", W'(rx_empty), W'(1));
    chk("jtx_rx_full", W'(full), W'(1));
    psh(32'hCAFEF00D);
    chk("jtx_push_drop", W'(rx_level), '0);
    pul(32'h10000000); pul(32'h10000001);
    wr(32'hE0E0E0E0); wr(32'hE1E1E1E1);      // wraps past entry 7
    chk("jtx_wrap_level", W'(tx_level), W'(8));
    for (int i = 2; i < 8; i++) pul(32'h10000000 + W'(i));
    pul(32'hE0E0E0E0);
    wr(32'hE2E2E2E2);
    join_tx = 1'b0; tick();                  // mode change flushes
    chk("jtx_exit_level", W'(tx_level), '0);
    chk("jtx_exit_full", W'(full), '0);

    // RX join: 2*D entries, TX held empty+full
    join_rx = 1'b1; tick();
    for (int i = 0; i < 8; i++) psh(32'h20000000 + W'(i));
    chk("jrx_level", W'(rx_level), W'(8));
    chk("jrx_full", W'(full), W'(1));
    chk("jrx_tx_full", W'(tx_full), W'(1));
    chk("jrx_tx_empty", W'(empty), W'(1));
    wr(32'h99999999);
    chk("jrx_over", W'(tx_over), W'(1));
    chk("jrx_tx_level", W'(tx_level), '0);
    rd(32'h20000000); rd(32'h20000001);
    psh(32'h2000000A); psh(32'h2000000B);
    for (int i = 2; i < 8; i++) rd(32'h20000000 + W'(i));
    rd(32'h2000000A); rd(32'h2000000B);
    join_rx = 1'b0; err_clr = 1'b1; tick();

    // Mixed concurrent traffic in split mode, checked by the model
    for (int i = 0; i < 60; i++) begin
      tx_wr = (i % 3) != 0;
      pull  = ((i % 4) == 1) || ((i % 5) == 0);
      push  = (i % 2) == 0;
      rx_rd = (i % 3) == 2 || (i > 40);
      tx_wdata = 32'hA0000000 + W'(i);
      din      = 32'hB0000000 + W'($urandom_range(0, 255));
      err_clr  = (i % 17) == 16;
      tick();
    end

    // Reset mid-traffic
    for (int i = 1; i <= 5; i++) wr(32'h30000000 + W'(i));
    psh(32'h40000001);
    tx_wr = 1'b1; push = 1'b1; pull = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    tx_wr = 1'b0; push = 1'b0; pull = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    wr(32'h50505050);
    pul(32'h50505050);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
